// File: rtl/mode_sequencer_n_if.sv
// mode_sequencer_n_if: switch/button inputs, source display words and sequencer status outputs
interface mode_sequencer_n_if #(
  parameter int N_MODES = 5,
  parameter int DISP_W  = 20
);
  logic [N_MODES-1:0] mode_sw;
  logic               help_sw;
  logic               demo_sw;
  logic               any_btn;
  logic               err_in;
  logic               err_ack;
  logic [DISP_W-1:0]  hello_disp;
  logic [DISP_W-1:0]  edit_disp;
  logic [DISP_W-1:0]  help_disp;
  logic [1:0]         kind;
  logic [3:0]         mode;
  logic [3:0]         help_page;
  logic               err_active;
  logic               timeout;
  logic [DISP_W-1:0]  disp;
  modport master (
    output mode_sw, help_sw, demo_sw, any_btn, err_in, err_ack, hello_disp, edit_disp, help_disp,
    input  kind, mode, help_page, err_active, timeout, disp
  );
  modport slave (
    input  mode_sw, help_sw, demo_sw, any_btn, err_in, err_ack, hello_disp, edit_disp, help_disp,
    output kind, mode, help_page, err_active, timeout, disp
  );
endinterface

// File: rtl/mode_sequencer_n.sv
// mode_sequencer_n: HELLO/EDIT/HELP/DEMO sequencer with error latch, idle timeout and display mux
module mode_sequencer_n #(
  parameter int                N_MODES     = 5,
  parameter int                DISP_W      = 20,
  parameter logic [31:0]       IDLE_CYC    = 32'd500_000_000,
  parameter logic [DISP_W-1:0] ERR_PATTERN = {5'd31, 5'd14, 5'd25, 5'd25}
) (
  input logic               clk,
  input logic               rst,
  mode_sequencer_n_if.slave bus
);
  typedef enum logic [1:0] {HELLO, EDIT, HELP, DEMO} kind_t;
  kind_t              st, nxt;
  logic [3:0]         hi, mode, help_page;
  logic               any_mode, act, to, err, tmo;
  logic [N_MODES+1:0] sw_q;
  logic [31:0]        idle;
  logic [DISP_W-1:0]  disp;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N_MODES; i++) if (bus.mode_sw[i]) hi = 4'(i);
  end
  assign any_mode = |bus.mode_sw;
  assign act = bus.any_btn | ({bus.mode_sw, bus.help_sw, bus.demo_sw} != sw_q);
  assign to  = (IDLE_CYC != 0) && (st != HELLO) && (idle == IDLE_CYC - 32'd1) && !act;
  // Timeout overrides every ordinary transition.
  always_comb begin
    nxt = st;
    if (to) nxt = HELLO;
    else case (st)
      HELLO:   nxt = (bus.any_btn | any_mode) ? EDIT : bus.help_sw ? HELP : bus.demo_sw ? DEMO : HELLO;
      DEMO:    nxt = (bus.any_btn | any_mode) ? EDIT : bus.help_sw ? HELP : DEMO;
      HELP:    nxt = (!bus.help_sw && bus.demo_sw) ? DEMO : (!bus.help_sw && any_mode) ? EDIT : HELP;
      default: nxt = bus.help_sw ? HELP : bus.demo_sw ? DEMO : EDIT;
    endcase
  end
  always_ff @(posedge clk) begin
    sw_q <= {bus.mode_sw, bus.help_sw, bus.demo_sw};
    if (rst) begin
      st        <= HELLO;
      mode      <= '0;
      help_page <= '0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      disp      <= '0;
      idle      <= '0;
    end else begin
      st  <= nxt;
      tmo <= to;
      if (nxt == EDIT) mode <= hi;
      if (st == HELP && bus.help_sw)
        help_page <= bus.demo_sw ? 4'(N_MODES + 1) : any_mode ? hi + 4'd1 : 4'd0;
      err  <= (st != EDIT || nxt != EDIT) ? 1'b0 : (bus.err_in && !err) ? 1'b1 : bus.err_ack ? 1'b0 : err;
      idle <= (act || nxt != st || st == HELLO) ? 32'd0 : (idle == IDLE_CYC) ? idle : idle + 32'd1;
      disp <= st == HELLO ? bus.hello_disp : st == EDIT ? (err ? ERR_PATTERN : bus.edit_disp) :
              st == HELP ? bus.help_disp : bus.edit_disp;
    end
  end
  assign bus.kind       = st;
  assign bus.mode       = mode;
  assign bus.help_page  = help_page;
  assign bus.err_active = err;
  assign bus.timeout    = tmo;
  assign bus.disp       = disp;
endmodule
